// File: rtl/lsu_pkg.sv
// Shared FSM encoding, funct3 codes and decode helper for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StWrite = 2'd2,
      StResp  = 2'd3
   } lsu_state_e;

   // RV32I load/store size codes (stores only use the first three)
   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   // True when funct3 names a legal access of the given direction
   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3Byte) || (f3 == F3Half) || (f3 == F3Word);
      if (!we) begin
         ok = ok || (f3 == F3ByteU) || (f3 == F3HalfU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling: merges store data into a RAM word and extracts/extends load data.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  byte_off_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] merged_o,
   output logic [31:0] loaded_o
);

   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [31:0] shifted;

   assign byte_sh = {byte_off_i, 3'b000};
   assign half_sh = {byte_off_i[1], 4'b0000};
   assign shifted = word_i >> byte_sh;

   // Store merge: replace only the addressed lanes of the old word
   always_comb begin
      merged_o = word_i;
      case (funct3_i)
         F3Byte:  merged_o[byte_sh +: 8]  = wdata_i[7:0];
         F3Half:  merged_o[half_sh +: 16] = wdata_i[15:0];
         F3Word:  merged_o                = wdata_i;
         default: merged_o                = word_i;
      endcase
   end

   // Load extract: lane shifted down to bit 0, then sign or zero extended
   always_comb begin
      loaded_o = 32'd0;
      case (funct3_i)
         F3Byte:  loaded_o = {{24{shifted[7]}}, shifted[7:0]};
         F3Half:  loaded_o = {{16{shifted[15]}}, shifted[15:0]};
         F3Word:  loaded_o = word_i;
         F3ByteU: loaded_o = {24'd0, shifted[7:0]};
         F3HalfU: loaded_o = {16'd0, shifted[15:0]};
         default: loaded_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time against a single-port word RAM.
// Sub-word stores are done as read-modify-write.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_address,
   output logic [31:0]       ram_write_data,
   input  logic [31:0]       ram_read_data
);

   lsu_state_e state_q, state_d;

   logic              we_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [31:0]       word_q;

   logic accept;
   logic misaligned;
   logic out_of_range;
   logic req_err;

   logic [31:0] merged;
   logic [31:0] loaded;

   assign accept = req_valid && (state_q == StIdle);

   // Request error decode, evaluated on the live request at accept time
   always_comb begin
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
      out_of_range = (req_addr >> (ADDR_W + 2)) != 32'd0;
      req_err      = misaligned || out_of_range || !funct3_legal(req_we, req_funct3);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_err) begin
                  state_d = StResp;
               end else if (req_we && (req_funct3 == F3Word)) begin
                  state_d = StWrite;
               end else begin
                  // loads, and SB/SH which need the old word first
                  state_d = StRead;
               end
            end
         end
         StRead:  state_d = we_q ? StWrite : StResp;
         StWrite: state_d = StResp;
         StResp:  state_d = resp_ready ? StIdle : StResp;
         default: state_d = StIdle;
      endcase
   end

   // Captured request and RAM word
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         err_q    <= 1'b0;
         word_q   <= 32'd0;
      end else begin
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[ADDR_W+1:0];
            wdata_q  <= req_wdata;
            err_q    <= req_err;
         end
         if (state_q == StRead) begin
            word_q <= ram_read_data;
         end
      end
   end

   lsu_align u_align (
      .funct3_i   (funct3_q),
      .byte_off_i (addr_q[1:0]),
      .word_i     (word_q),
      .wdata_i    (wdata_q),
      .merged_o   (merged),
      .loaded_o   (loaded)
   );

   // Outputs decoded from state; write is suppressed in a reset cycle
   always_comb begin
      req_ready      = (state_q == StIdle);
      resp_valid     = (state_q == StResp);
      resp_err       = (state_q == StResp) && err_q;
      resp_rdata     = ((state_q == StResp) && !err_q && !we_q) ? loaded : 32'd0;
      ram_we         = (state_q == StWrite) && !rst;
      ram_address    = addr_q[ADDR_W+1:2];
      ram_write_data = merged;
   end

endmodule
